gat_feat_pingpong_ctrl: RTL
===========================

Name: gat_feat_pingpong_ctrl

Overview:
Ping-pong feature-buffer controller that generalises the per-layer memory muxing to NUM_LAYERS GAT layers. It owns two feature banks of DEPTH words each. PS loads layer-0 input features into bank 0. Layer L reads bank L%2 and writes bank (L+1)%2, and the controller swaps banks on each layer_done. It sits between the PS load path and the conv pipeline and replaces per-layer address muxing with a sequenced bank manager.

Parameters:
DATA_WIDTH, 8, feature word width
DEPTH, 43328, words per bank (NUM_SUBGRAPHS*NUM_FEATURE_OUT)
NUM_LAYERS, 2, layers to sequence (1..15)
READ_LATENCY, 1, read pipeline depth in cycles (1 or 2)
ADDR_W (local), $clog2(DEPTH), address width
LAYER_W (local), $clog2(NUM_LAYERS)+1, layer index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ps_din  in  DATA_WIDTH  PS load data
ps_ena  in  1  PS write enable
ps_addr  in  ADDR_W  PS write address (bank 0)
ps_load_done  in  1  pulse: PS load complete
start  in  1  pulse: begin layer 0
clear  in  1  pulse: soft return to IDLE
layer_done  in  1  pulse: current layer finished writing
rd_en  in  1  pipeline read request
rd_addr  in  ADDR_W  read address (current source bank)
rd_dout  out  DATA_WIDTH  read data
rd_valid  out  1  rd_dout valid
wr_en  in  1  pipeline write
wr_addr  in  ADDR_W  write address (current destination bank)
wr_din  in  DATA_WIDTH  write data
cur_layer  out  LAYER_W  active layer index
layer_start  out  1  one-cycle pulse when a layer may begin
busy  out  1  high in RUN or SWAP
all_done  out  1  high in DONE
last_wr_count  out  ADDR_W+1  writes accepted in the previous layer
err  out  1  sticky protocol error

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; rd pipeline flushed; bank contents not cleared.
- States: IDLE (PS loading) -> READY on ps_load_done -> RUN on start -> SWAP on layer_done -> RUN, or -> DONE on layer_done when cur_layer==NUM_LAYERS-1.
- clear returns to IDLE from any state next cycle. clear clears err, cur_layer and last_wr_count, and flushes rd pipeline.
- IDLE: ps_ena writes bank 0 at ps_addr.
- ps_ena in any state other than IDLE: write ignored; err set.
- RUN: src bank = cur_layer[0]; dst bank = ~cur_layer[0]. rd_en reads src bank; wr_en writes dst bank.
- Read timing: rd_valid=1 exactly READ_LATENCY cycles after an accepted rd_en, otherwise 0. rd_dout holds its last value when rd_valid=0.
- Back-to-back reads: fully pipelined, one read per cycle.
- DONE: rd_en reads result bank NUM_LAYERS%2; wr_en ignored with err set; all_done=1 until clear.
- rd_en outside RUN/DONE, or wr_en outside RUN: ignored; err set.
- Address >= DEPTH on any port: access ignored; err set. No wrap-around.
- layer_start: pulses one cycle after the start-accepted edge (READY->RUN) and on each SWAP->RUN transition.
- SWAP lasts exactly 1 cycle. It increments cur_layer; rd_en/wr_en in SWAP are ignored with err set.
- layer_done with wr_en in the same cycle: the write commits to the old dst bank before the swap. wr_count includes that write.
- wr_count: counts accepted writes in the current layer. On layer_done it is latched into last_wr_count (saturating at DEPTH), then zeroed.
- layer_done outside RUN, start outside READY, ps_load_done outside IDLE: ignored; err set.
- Reads already in flight when SWAP/DONE is entered still complete with rd_valid.
- Same-bank read/write hazard cannot occur in RUN by construction.

Test Plan:
- Load+1 layer: reset; PS writes 0..15 at addr 0..15; ps_load_done; start; read addr 5 -> rd_valid 1 cycle later (READY_LATENCY=1), rd_dout=5; layer_start seen 1 cycle after start.
- Ping-pong, NUM_LAYERS=2: layer0 writes addr k=k+100 (16 writes), layer_done -> last_wr_count=16, cur_layer=1; layer1 reads addr 3 -> 103; layer1 writes 200+k, layer_done -> DONE; read addr 3 -> 203; all_done=1.
- Simultaneous: wr_en (addr 7, data 0x55) with layer_done -> next layer reads addr 7 = 0x55; last_wr_count includes it.
- Errors: ps_ena in RUN, wr_en in SWAP, rd_addr=DEPTH -> err=1, memory unchanged (re-read addr 0 returns prior value); clear -> err=0, state IDLE.
- READ_LATENCY=2: 4 back-to-back reads -> rd_valid high for 4 consecutive cycles starting 2 cycles after the first rd_en, data in order.
- Async reset mid-RUN: rst_n low between clock edges -> outputs 0 immediately; after release, a PS reload and run complete correctly.

Source files
------------

// File: rtl/gat_feat_pingpong_ctrl.sv
// ---------------------------------------------------------------------------
// gat_feat_pingpong_ctrl
//
// Ping-pong feature-buffer manager for a stack of GAT layers. Two feature
// banks of DEPTH words are owned here. The PS loads layer-0 features into
// bank 0 while IDLE. Layer L reads bank L%2 and writes bank (L+1)%2, and the
// banks swap on every layer_done. After the last layer, the result bank
// (NUM_LAYERS%2) stays readable until clear.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   ps_din/ps_ena/ps_addr   PS load write port (bank 0, IDLE only)
//   ps_load_done      pulse: PS load finished (IDLE -> READY)
//   start             pulse: begin layer 0 (READY -> RUN)
//   clear             pulse: soft return to IDLE, clears err/counters
//   layer_done        pulse: current layer finished writing
//   rd_en/rd_addr     pipeline read of the current source bank
//   rd_dout/rd_valid  read data, valid READ_LATENCY cycles after rd_en
//   wr_en/wr_addr/wr_din    pipeline write to the current destination bank
//   cur_layer         active layer index
//   layer_start       one-cycle pulse when a layer may begin
//   busy              high in RUN or SWAP
//   all_done          high in DONE
//   last_wr_count     writes accepted during the previous layer
//   err               sticky protocol error
// ---------------------------------------------------------------------------
module gat_feat_pingpong_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 43328,
  parameter int NUM_LAYERS   = 2,
  parameter int READ_LATENCY = 1,
  localparam int ADDR_W      = $clog2(DEPTH),
  localparam int LAYER_W     = $clog2(NUM_LAYERS) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] ps_din,
  input  logic                  ps_ena,
  input  logic [ADDR_W-1:0]     ps_addr,
  input  logic                  ps_load_done,
  input  logic                  start,
  input  logic                  clear,
  input  logic                  layer_done,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_dout,
  output logic                  rd_valid,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_din,
  output logic [LAYER_W-1:0]    cur_layer,
  output logic                  layer_start,
  output logic                  busy,
  output logic                  all_done,
  output logic [ADDR_W:0]       last_wr_count,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READY,
    S_RUN,
    S_SWAP,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0]    DEPTH_V     = (ADDR_W + 1)'(DEPTH);
  localparam logic [LAYER_W-1:0] LAST_LAYER  = LAYER_W'(NUM_LAYERS - 1);
  localparam logic               RESULT_BANK = 1'(NUM_LAYERS % 2);

  // Addresses are checked against DEPTH rather than 2**ADDR_W: out-of-range
  // accesses are dropped, never wrapped.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_V;
  endfunction

  // Write counter saturates at DEPTH so last_wr_count never exceeds a bank.
  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] c,
                                              input logic            inc);
    if (inc && (c < DEPTH_V)) return c + (ADDR_W + 1)'(1);
    return c;
  endfunction

  state_t          state;
  logic [ADDR_W:0] wr_count;

  logic in_idle, in_run, in_done;
  logic ps_acc, rd_acc, wr_acc;
  logic rd_bank, wr_bank;
  logic err_evt;

  always_comb begin
    in_idle = (state == S_IDLE);
    in_run  = (state == S_RUN);
    in_done = (state == S_DONE);

    // clear takes the whole cycle: no access and no error is recorded.
    ps_acc = !clear && ps_ena && in_idle && addr_ok(ps_addr);
    rd_acc = !clear && rd_en && (in_run || in_done) && addr_ok(rd_addr);
    wr_acc = !clear && wr_en && in_run && addr_ok(wr_addr);

    rd_bank = in_done ? RESULT_BANK : cur_layer[0];
    wr_bank = ~cur_layer[0];

    err_evt = !clear && (
                (ps_ena && !(in_idle && addr_ok(ps_addr))) ||
                (rd_en  && !((in_run || in_done) && addr_ok(rd_addr))) ||
                (wr_en  && !(in_run && addr_ok(wr_addr))) ||
                (layer_done   && !in_run) ||
                (start        && (state != S_READY)) ||
                (ps_load_done && !in_idle));
  end

  // Feature banks. PS writes and pipeline writes to bank 0 live in disjoint
  // states, so the priority below never actually arbitrates.
  logic [DATA_WIDTH-1:0] bank0 [DEPTH];
  logic [DATA_WIDTH-1:0] bank1 [DEPTH];

  always_ff @(posedge clk) begin
    if (ps_acc)
      bank0[ps_addr] <= ps_din;
    else if (wr_acc && !wr_bank)
      bank0[wr_addr] <= wr_din;
  end

  always_ff @(posedge clk) begin
    if (wr_acc && wr_bank)
      bank1[wr_addr] <= wr_din;
  end

  // ---- read stage p0: bank read register ----
  logic [DATA_WIDTH-1:0] rd_data_p0;
  logic                  vld_p0;
  logic [DATA_WIDTH-1:0] rd_data_out;
  logic                  rd_vld_out;
  logic                  has_data;

  always_ff @(posedge clk) begin
    if (rd_acc)
      rd_data_p0 <= rd_bank ? bank1[rd_addr] : bank0[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p0 <= 1'b0;
    else        vld_p0 <= rd_acc;
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      // ---- read stage p1: optional output register ----
      logic [DATA_WIDTH-1:0] rd_data_p1;
      logic                  vld_p1;

      always_ff @(posedge clk) begin
        if (vld_p0 && !clear)
          rd_data_p1 <= rd_data_p0;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_p1 <= 1'b0;
        else        vld_p1 <= vld_p0 && !clear;
      end

      assign rd_data_out = rd_data_p1;
      assign rd_vld_out  = vld_p1;
    end else begin : g_lat1
      assign rd_data_out = rd_data_p0;
      assign rd_vld_out  = vld_p0;
    end
  endgenerate

  // The data registers carry no reset; has_data forces rd_dout to zero until
  // the first completed read after reset, after which rd_dout simply holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) has_data <= 1'b0;
    else        has_data <= has_data | rd_vld_out;
  end

  assign rd_dout  = (has_data || rd_vld_out) ? rd_data_out : '0;
  assign rd_valid = rd_vld_out;

  // ---- sequencer ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cur_layer     <= '0;
      layer_start   <= 1'b0;
      busy          <= 1'b0;
      all_done      <= 1'b0;
      last_wr_count <= '0;
      wr_count      <= '0;
      err           <= 1'b0;
    end else if (clear) begin
      state         <= S_IDLE;
      cur_layer     <= '0;
      layer_start   <= 1'b0;
      busy          <= 1'b0;
      all_done      <= 1'b0;
      last_wr_count <= '0;
      wr_count      <= '0;
      err           <= 1'b0;
    end else begin
      layer_start <= 1'b0;
      if (err_evt) err <= 1'b1;

      unique case (state)
        S_IDLE: begin
          if (ps_load_done) state <= S_READY;
        end
        S_READY: begin
          if (start) begin
            state       <= S_RUN;
            layer_start <= 1'b1;
            busy        <= 1'b1;
            wr_count    <= '0;
          end
        end
        S_RUN: begin
          if (layer_done) begin
            // A write in the layer_done cycle still belongs to this layer.
            last_wr_count <= sat_inc(wr_count, wr_acc);
            wr_count      <= '0;
            if (cur_layer == LAST_LAYER) begin
              state    <= S_DONE;
              busy     <= 1'b0;
              all_done <= 1'b1;
            end else begin
              state <= S_SWAP;
            end
          end else begin
            wr_count <= sat_inc(wr_count, wr_acc);
          end
        end
        S_SWAP: begin
          cur_layer   <= cur_layer + LAYER_W'(1);
          state       <= S_RUN;
          layer_start <= 1'b1;
        end
        S_DONE: begin
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
